// File: rtl/sg_pkg.sv
// rtl/sg_pkg.sv - shared types and constants for the scatter-gather read controller
package sg_pkg;

    localparam int ADDR_W         = 32;
    localparam int DEF_ELEM_SHIFT = 2;
    localparam int IDX_BYTES      = 4;

    typedef enum logic [2:0] {
        IDLE,
        IDX_REQ,
        IDX_WAIT,
        DAT_REQ,
        DAT_WAIT,
        EMIT
    } sg_state_t;

endpackage

// File: rtl/sg_addr_calc.sv
// rtl/sg_addr_calc.sv - element byte address from array base and element index
module sg_addr_calc
    import sg_pkg::*;
#(
    parameter int ELEM_SHIFT = DEF_ELEM_SHIFT
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [31:0]       index,
    output logic [ADDR_W-1:0] addr
);

    // Shifted-out index bits and the carry out of the add are dropped on purpose.
    assign addr = base + (index << ELEM_SHIFT);

endmodule

// File: rtl/sg_gather_ctrl.sv
// rtl/sg_gather_ctrl.sv - index-driven gather controller; SG_BOUNDS_CHECK_EN enables index bounds checking
module sg_gather_ctrl
    import sg_pkg::*;
#(
    parameter int ELEM_SHIFT = DEF_ELEM_SHIFT,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] idx_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic [31:0]       idx_limit,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic              out_last,
    input  logic              out_ready
);

    sg_state_t         state, state_nxt;
    logic [ADDR_W-1:0] base_q, idx_ptr, dat_addr;
    logic [CNT_W-1:0]  remaining;
    logic [31:0]       index_q, data_q;
    logic              done_q, done_nxt, err_q, idx_oob, last_elem;

    sg_addr_calc #(.ELEM_SHIFT(ELEM_SHIFT)) u_addr_calc (
        .base  (base_q),
        .index (index_q),
        .addr  (dat_addr)
    );

`ifdef SG_BOUNDS_CHECK_EN
    assign idx_oob = (mem_rdata >= idx_limit);
    assign err     = err_q;
`else
    logic unused_cfg;
    assign idx_oob    = 1'b0;
    assign err        = 1'b0;
    assign unused_cfg = ^{idx_limit, err_q};
`endif

    assign last_elem = (remaining == CNT_W'(1));
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign out_data  = data_q;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count == '0) done_nxt  = 1'b1;
                    else             state_nxt = IDX_REQ;
                end
            end
            IDX_REQ: begin
                mem_req  = 1'b1;
                mem_addr = idx_ptr;
                if (mem_gnt) state_nxt = IDX_WAIT;
            end
            IDX_WAIT: begin
                if (mem_rvalid) begin
                    // An out-of-range index consumes its element without touching the data array.
                    if (!idx_oob)       state_nxt = DAT_REQ;
                    else if (last_elem) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else            state_nxt = IDX_REQ;
                end
            end
            DAT_REQ: begin
                mem_req  = 1'b1;
                mem_addr = dat_addr;
                if (mem_gnt) state_nxt = DAT_WAIT;
            end
            DAT_WAIT: begin
                if (mem_rvalid) state_nxt = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_last  = last_elem;
                if (out_ready) begin
                    if (last_elem) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDX_REQ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_q    <= '0;
            idx_ptr   <= '0;
            remaining <= '0;
            index_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
            if (state == IDLE && start) begin
                base_q    <= base_addr;
                idx_ptr   <= idx_addr;
                remaining <= count;
                err_q     <= 1'b0;
            end
            if (state == IDX_REQ && mem_gnt)
                idx_ptr <= idx_ptr + ADDR_W'(IDX_BYTES);
            if (state == IDX_WAIT && mem_rvalid) begin
                index_q <= mem_rdata;
                if (idx_oob) begin
                    remaining <= remaining - CNT_W'(1);
                    err_q     <= 1'b1;
                end
            end
            if (state == DAT_WAIT && mem_rvalid)
                data_q <= mem_rdata;
            if (state == EMIT && out_ready)
                remaining <= remaining - CNT_W'(1);
        end
    end

endmodule
